// File: rtl/bsg_nor3_rr_share.sv
// Round-robin time-shared NOR3 unit feeding a single-entry output register.
// Optional stall counter output enabled by BSG_NOR3_RR_SHARE_STATS_EN.
module bsg_nor3_rr_share
  #(parameter int width_p = 16
   ,parameter int els_p   = 4
   ,localparam int tag_w_lp = (els_p > 1) ? $clog2(els_p) : 1
   )
   (input  logic                      clk_i
   ,input  logic                      reset_i
   ,input  logic [els_p-1:0]          v_i
   ,input  logic [els_p*width_p-1:0]  a_i
   ,input  logic [els_p*width_p-1:0]  b_i
   ,input  logic [els_p*width_p-1:0]  c_i
   ,output logic [els_p-1:0]          yumi_o
   ,output logic                      v_o
   ,output logic [width_p-1:0]        data_o
   ,output logic [tag_w_lp-1:0]       tag_o
   ,input  logic                      yumi_i
`ifdef BSG_NOR3_RR_SHARE_STATS_EN
   ,output logic [15:0]               stall_cnt_o
`endif
   );

    logic                v_q, v_d;
    logic [width_p-1:0]  data_q, data_d;
    logic [tag_w_lp-1:0] tag_q, tag_d;
    logic [tag_w_lp-1:0] ptr_q, ptr_d;

    logic                free;
    logic                hi_v, lo_v, grant_v;
    logic [tag_w_lp-1:0] hi_idx, lo_idx, grant_idx, ptr_nxt;
    logic [width_p-1:0]  nor_res;

    always_comb begin
        free    = ~v_q | yumi_i;
        hi_v    = 1'b0;
        lo_v    = 1'b0;
        hi_idx  = '0;
        lo_idx  = '0;
        // Wrapped search split in two: first valid at/above ptr, else first below it.
        for (int unsigned k = 0; k < els_p; k++) begin
            if (v_i[k]) begin
                if (k >= 32'(ptr_q)) begin
                    if (!hi_v) begin
                        hi_v   = 1'b1;
                        hi_idx = tag_w_lp'(k);
                    end
                end else if (!lo_v) begin
                    lo_v   = 1'b1;
                    lo_idx = tag_w_lp'(k);
                end
            end
        end
        grant_v   = free & ~reset_i & (hi_v | lo_v);
        grant_idx = hi_v ? hi_idx : lo_idx;

        yumi_o  = '0;
        nor_res = '0;
        ptr_nxt = '0;
        for (int unsigned k = 0; k < els_p; k++) begin
            if (grant_idx == tag_w_lp'(k)) begin
                yumi_o[k] = grant_v;
                nor_res   = ~(a_i[k*width_p +: width_p]
                            | b_i[k*width_p +: width_p]
                            | c_i[k*width_p +: width_p]);
                ptr_nxt   = tag_w_lp'((k + 1) % els_p);
            end
        end

        v_d    = v_q;
        data_d = data_q;
        tag_d  = tag_q;
        ptr_d  = ptr_q;
        if (free) begin
            v_d = grant_v;
            if (grant_v) begin
                data_d = nor_res;
                tag_d  = grant_idx;
                ptr_d  = ptr_nxt;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_q    <= 1'b0;
            data_q <= '0;
            tag_q  <= '0;
            ptr_q  <= '0;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
            tag_q  <= tag_d;
            ptr_q  <= ptr_d;
        end
    end

    assign v_o    = v_q;
    assign data_o = data_q;
    assign tag_o  = tag_q;

`ifdef BSG_NOR3_RR_SHARE_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (v_q && !yumi_i && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) stall_cnt_q <= '0;
        else         stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

`ifndef SYNTHESIS
    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_q)
        else $error("yumi_i asserted while v_o is low");
`endif

endmodule
